// File: rtl/player_seq_if.sv
// Command and status bundle between a playback controller (master) and player_seq (slave).
interface player_seq_if;
    logic       play;
    logic       pause;
    logic       stop;
    logic       loop_en;
    logic [7:0] ibeat;
    logic       beat_tick;
    logic       playing;
    logic       done;
    logic       mute;

    modport master (
        output play, pause, stop, loop_en,
        input  ibeat, beat_tick, playing, done, mute
    );

    modport slave (
        input  play, pause, stop, loop_en,
        output ibeat, beat_tick, playing, done, mute
    );
endinterface

// File: rtl/player_seq.sv
// Song beat sequencer: steps ibeat every BEAT_DIV clocks under play/pause/stop control,
// optionally looping at the end of the song. All outputs are registered.
module player_seq #(
    parameter int unsigned BEAT_DIV = 32'd12500000,
    parameter int unsigned SONG_LEN = 9'd128
) (
    input logic         clk,
    input logic         reset,
    player_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StPlaying, StPaused, StDone} state_e;
    typedef enum logic [1:0] {CmdNone, CmdPlay, CmdPause, CmdStop} cmd_e;

    localparam logic [31:0] DivLast  = BEAT_DIV - 32'd1;
    localparam logic [7:0]  BeatLast = 8'(SONG_LEN - 32'd1);

    state_e      state_q, state_d;
    logic [31:0] div_cnt_q, div_cnt_d;
    logic [7:0]  ibeat_q, ibeat_d;
    logic        beat_tick_q, beat_tick_d;
    logic        playing_q, done_q, mute_q;
    cmd_e        cmd;

    // Only the highest-priority command is seen each cycle.
    always_comb begin
        cmd = CmdNone;
        if (bus.stop) begin
            cmd = CmdStop;
        end else if (bus.pause) begin
            cmd = CmdPause;
        end else if (bus.play) begin
            cmd = CmdPlay;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        ibeat_d     = ibeat_q;
        beat_tick_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd == CmdPlay) begin
                    state_d   = StPlaying;
                    div_cnt_d = '0;
                    ibeat_d   = '0;
                end
            end
            StPlaying: begin
                if (cmd == CmdStop) begin
                    state_d   = StIdle;
                    div_cnt_d = '0;
                    ibeat_d   = '0;
                end else if (cmd == CmdPause) begin
                    state_d = StPaused;
                end else if (div_cnt_q == DivLast) begin
                    div_cnt_d   = '0;
                    beat_tick_d = 1'b1;
                    if (ibeat_q != BeatLast) begin
                        ibeat_d = ibeat_q + 8'd1;
                    end else if (bus.loop_en) begin
                        ibeat_d = '0;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 32'd1;
                end
            end
            StPaused: begin
                if (cmd == CmdStop) begin
                    state_d   = StIdle;
                    div_cnt_d = '0;
                    ibeat_d   = '0;
                end else if (cmd == CmdPlay) begin
                    state_d = StPlaying;
                end
            end
            StDone: begin
                if (cmd == CmdStop) begin
                    state_d   = StIdle;
                    div_cnt_d = '0;
                    ibeat_d   = '0;
                end else if (cmd == CmdPlay) begin
                    state_d   = StPlaying;
                    div_cnt_d = '0;
                    ibeat_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            div_cnt_q   <= '0;
            ibeat_q     <= '0;
            beat_tick_q <= 1'b0;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
            mute_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            ibeat_q     <= ibeat_d;
            beat_tick_q <= beat_tick_d;
            playing_q   <= (state_d == StPlaying);
            done_q      <= (state_d == StDone);
            mute_q      <= (state_d != StPlaying);
        end
    end

    assign bus.ibeat     = ibeat_q;
    assign bus.beat_tick = beat_tick_q;
    assign bus.playing   = playing_q;
    assign bus.done      = done_q;
    assign bus.mute      = mute_q;

endmodule
